// File: rtl/sne_evt_stream_merge.sv
// N-channel valid/ready event merger with round-robin or fixed-priority arbitration and a 2-entry output FIFO.
// Optional accepted-event counter enabled by defining SNE_EVT_MERGE_CNT_EN.
module sne_evt_stream_merge #(
  parameter  int N_CH     = 4,
  parameter  int DW       = 32,
  parameter  int ARB_MODE = 0,
  localparam int SRC_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N_CH-1:0]      in_valid_i,
  input  logic [N_CH*DW-1:0]   in_evt_i,
  output logic [N_CH-1:0]      in_ready_o,
  output logic                 out_valid_o,
  output logic [DW-1:0]        out_evt_o,
  output logic [SRC_W-1:0]     out_src_o,
  input  logic                 out_ready_i,
  input  logic                 cnt_clr_i,
  output logic [15:0]          cnt_o
);

  logic [SRC_W-1:0] ptr_q;
  logic [1:0]       count_p1;
  logic [DW-1:0]    head_evt_p1;
  logic [SRC_W-1:0] head_src_p1;
  logic [DW-1:0]    tail_evt_p1;
  logic [SRC_W-1:0] tail_src_p1;

  logic             gnt_vld_p0;
  logic [SRC_W-1:0] gnt_src_p0;
  logic [DW-1:0]    gnt_evt_p0;
  logic             full;
  logic             push_p0;
  logic             pop_p1;

  // Stage p0: combinational arbitration over the input valids
  always_comb begin
    int idx;
    idx        = 0;
    gnt_vld_p0 = 1'b0;
    gnt_src_p0 = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ARB_MODE == 0) begin
        idx = int'(ptr_q) + i;
        if (idx >= N_CH) idx = idx - N_CH;
      end else begin
        idx = i;
      end
      if (!gnt_vld_p0 && in_valid_i[idx]) begin
        gnt_vld_p0 = 1'b1;
        gnt_src_p0 = SRC_W'(idx);
      end
    end
  end

  always_comb begin
    gnt_evt_p0 = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt_src_p0 == SRC_W'(k)) gnt_evt_p0 = in_evt_i[k*DW +: DW];
    end
  end

  // full comes straight from a flop, so out_ready_i never reaches in_ready_o
  assign full    = (count_p1 == 2'd2);
  assign push_p0 = gnt_vld_p0 & ~full & rst_ni;
  assign pop_p1  = out_valid_o & out_ready_i;

  always_comb begin
    in_ready_o = '0;
    for (int k = 0; k < N_CH; k++) begin
      in_ready_o[k] = push_p0 && (gnt_src_p0 == SRC_W'(k));
    end
  end

  // Stage p1: FIFO head (visible output), count and arbitration pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      count_p1    <= 2'd0;
      head_evt_p1 <= '0;
      head_src_p1 <= '0;
    end else begin
      if (ARB_MODE == 0 && push_p0) begin
        if (gnt_src_p0 == SRC_W'(N_CH - 1)) ptr_q <= '0;
        else                                ptr_q <= gnt_src_p0 + SRC_W'(1);
      end
      case ({push_p0, pop_p1})
        2'b10: begin
          if (count_p1 == 2'd0) begin
            head_evt_p1 <= gnt_evt_p0;
            head_src_p1 <= gnt_src_p0;
          end
          count_p1 <= count_p1 + 2'd1;
        end
        2'b01: begin
          if (count_p1 == 2'd2) begin
            head_evt_p1 <= tail_evt_p1;
            head_src_p1 <= tail_src_p1;
          end
          count_p1 <= count_p1 - 2'd1;
        end
        2'b11: begin
          // Only reachable at count 1: the new event replaces the departing head
          head_evt_p1 <= gnt_evt_p0;
          head_src_p1 <= gnt_src_p0;
        end
        default: ;
      endcase
    end
  end

  // Tail payload carries no reset; it is only read once count reaches 2
  always_ff @(posedge clk_i) begin
    if (push_p0 && !pop_p1 && count_p1 == 2'd1) begin
      tail_evt_p1 <= gnt_evt_p0;
      tail_src_p1 <= gnt_src_p0;
    end
  end

  assign out_valid_o = (count_p1 != 2'd0);
  assign out_evt_o   = head_evt_p1;
  assign out_src_o   = head_src_p1;

`ifdef SNE_EVT_MERGE_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (cnt_clr_i) begin
      cnt_q <= '0;
    end else if (push_p0 && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign cnt_o = cnt_q;
`else
  logic cnt_clr_unused;
  assign cnt_clr_unused = cnt_clr_i;
  assign cnt_o          = '0;
`endif

endmodule

// File: tb/tb_sne_evt_stream_merge.sv
// Directed bench for sne_evt_stream_merge: a round-robin and a fixed-priority instance share one stimulus.
module tb_sne_evt_stream_merge;

  localparam int N_CH  = 4;
  localparam int DW    = 32;
  localparam int SRC_W = 2;

  logic                clk;
  logic                rst_n;
  logic [N_CH-1:0]     in_valid;
  logic [N_CH*DW-1:0]  in_evt;
  logic                out_ready;
  logic                cnt_clr;

  logic [N_CH-1:0]     rr_in_ready;
  logic                rr_out_valid;
  logic [DW-1:0]       rr_out_evt;
  logic [SRC_W-1:0]    rr_out_src;
  logic [15:0]         rr_cnt;

  logic [N_CH-1:0]     fx_in_ready;
  logic                fx_out_valid;
  logic [DW-1:0]       fx_out_evt;
  logic [SRC_W-1:0]    fx_out_src;
  logic [15:0]         fx_cnt;

  int total;
  int bad;

  sne_evt_stream_merge #(.N_CH(N_CH), .DW(DW), .ARB_MODE(0)) dut_rr (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_evt_i(in_evt),
    .in_ready_o(rr_in_ready), .out_valid_o(rr_out_valid), .out_evt_o(rr_out_evt),
    .out_src_o(rr_out_src), .out_ready_i(out_ready), .cnt_clr_i(cnt_clr), .cnt_o(rr_cnt)
  );

  sne_evt_stream_merge #(.N_CH(N_CH), .DW(DW), .ARB_MODE(1)) dut_fx (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_evt_i(in_evt),
    .in_ready_o(fx_in_ready), .out_valid_o(fx_out_valid), .out_evt_o(fx_out_evt),
    .out_src_o(fx_out_src), .out_ready_i(out_ready), .cnt_clr_i(cnt_clr), .cnt_o(fx_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_default_evts();
    for (int k = 0; k < N_CH; k++) in_evt[k*DW +: DW] = 32'hA000_0000 | 32'(k);
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    set_default_evts();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    set_default_evts();
    @(negedge clk);
    total++; if (rr_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", rr_out_valid); end
    total++; if (rr_out_evt !== 32'h0) begin bad++; $display("FAIL reset_out_evt got=%h want=0", rr_out_evt); end
    total++; if (rr_out_src !== 2'd0) begin bad++; $display("FAIL reset_out_src got=%0d want=0", rr_out_src); end
    total++; if (rr_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%h want=0", rr_cnt); end
    total++; if (rr_in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready_rr got=%b want=0000", rr_in_ready); end
    total++; if (fx_in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready_fx got=%b want=0000", fx_in_ready); end
    in_valid = '0;
    rst_n    = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rr_fairness();
    apply_reset();
    out_ready = 1'b1;
    in_valid  = 4'hF;
    #1;
    total++; if (rr_in_ready !== 4'b0001) begin bad++; $display("FAIL rr_first_ready got=%b want=0001", rr_in_ready); end
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      total++; if (rr_out_valid !== 1'b1) begin bad++; $display("FAIL rr_valid cyc=%0d got=%b want=1", i, rr_out_valid); end
      total++; if (rr_out_src !== SRC_W'((i - 1) % 4)) begin bad++; $display("FAIL rr_src cyc=%0d got=%0d want=%0d", i, rr_out_src, (i - 1) % 4); end
      total++; if (rr_out_evt !== (32'hA000_0000 | 32'((i - 1) % 4))) begin bad++; $display("FAIL rr_evt cyc=%0d got=%h want=%h", i, rr_out_evt, 32'hA000_0000 | 32'((i - 1) % 4)); end
      total++; if (rr_in_ready !== 4'(1 << (i % 4))) begin bad++; $display("FAIL rr_ready cyc=%0d got=%b want=%b", i, rr_in_ready, 4'(1 << (i % 4))); end
    end
    in_valid = '0;
    repeat (2) @(negedge clk);
    total++; if (rr_out_valid !== 1'b0) begin bad++; $display("FAIL rr_drain got=%b want=0", rr_out_valid); end
  endtask

  task automatic test_fixed_priority();
    apply_reset();
    out_ready = 1'b1;
    in_valid  = 4'b1010;
    #1;
    total++; if (fx_in_ready !== 4'b0010) begin bad++; $display("FAIL fx_first_ready got=%b want=0010", fx_in_ready); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      total++; if (fx_out_src !== 2'd1 || fx_out_valid !== 1'b1) begin bad++; $display("FAIL fx_src cyc=%0d got=%0d/%b want=1/1", i, fx_out_src, fx_out_valid); end
      total++; if (fx_in_ready !== 4'b0010) begin bad++; $display("FAIL fx_ready cyc=%0d got=%b want=0010", i, fx_in_ready); end
    end
    in_valid = 4'b1000;
    #1;
    total++; if (fx_in_ready !== 4'b1000) begin bad++; $display("FAIL fx_ready_ch3 got=%b want=1000", fx_in_ready); end
    @(negedge clk);
    total++; if (fx_out_src !== 2'd3 || fx_out_evt !== 32'hA000_0003) begin bad++; $display("FAIL fx_ch3 got=%0d/%h want=3/a0000003", fx_out_src, fx_out_evt); end
    in_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready        = 1'b0;
    in_valid         = 4'b0001;
    in_evt[0 +: DW]  = 32'h0000_AAAA;
    @(negedge clk);
    total++; if (rr_out_valid !== 1'b1 || rr_out_evt !== 32'h0000_AAAA) begin bad++; $display("FAIL bp_first got=%b/%h want=1/0000aaaa", rr_out_valid, rr_out_evt); end
    in_evt[0 +: DW] = 32'h0000_BBBB;
    #1;
    total++; if (rr_in_ready !== 4'b0001) begin bad++; $display("FAIL bp_ready_second got=%b want=0001", rr_in_ready); end
    @(negedge clk);
    in_evt[0 +: DW] = 32'h0000_CCCC;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (rr_in_ready !== 4'b0000) begin bad++; $display("FAIL bp_full_ready cyc=%0d got=%b want=0000", i, rr_in_ready); end
      total++; if (rr_out_evt !== 32'h0000_AAAA || rr_out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h want=1/0000aaaa", i, rr_out_valid, rr_out_evt); end
      @(negedge clk);
    end
    in_valid  = '0;
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (rr_out_valid !== 1'b1 || rr_out_evt !== 32'h0000_BBBB) begin bad++; $display("FAIL bp_second_out got=%b/%h want=1/0000bbbb", rr_out_valid, rr_out_evt); end
    @(negedge clk);
    total++; if (rr_out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", rr_out_valid); end
  endtask

  task automatic test_push_pop();
    apply_reset();
    out_ready       = 1'b0;
    in_valid        = 4'b0001;
    in_evt[0 +: DW] = 32'h0000_1111;
    @(negedge clk);
    total++; if (rr_out_evt !== 32'h0000_1111) begin bad++; $display("FAIL pp_x got=%h want=00001111", rr_out_evt); end
    out_ready        = 1'b1;
    in_valid         = 4'b0010;
    in_evt[DW +: DW] = 32'h0000_2222;
    #1;
    total++; if (rr_in_ready !== 4'b0010) begin bad++; $display("FAIL pp_ready1 got=%b want=0010", rr_in_ready); end
    @(negedge clk);
    total++; if (rr_out_evt !== 32'h0000_2222 || rr_out_src !== 2'd1) begin bad++; $display("FAIL pp_y got=%h/%0d want=00002222/1", rr_out_evt, rr_out_src); end
    in_valid           = 4'b0100;
    in_evt[2*DW +: DW] = 32'h0000_3333;
    #1;
    total++; if (rr_in_ready !== 4'b0100) begin bad++; $display("FAIL pp_ready2 got=%b want=0100", rr_in_ready); end
    @(negedge clk);
    total++; if (rr_out_evt !== 32'h0000_3333 || rr_out_src !== 2'd2) begin bad++; $display("FAIL pp_z got=%h/%0d want=00003333/2", rr_out_evt, rr_out_src); end
    in_valid = '0;
    @(negedge clk);
    total++; if (rr_out_valid !== 1'b0) begin bad++; $display("FAIL pp_empty got=%b want=0", rr_out_valid); end
  endtask

  task automatic test_reset_midburst();
    apply_reset();
    out_ready = 1'b0;
    in_valid  = 4'hF;
    repeat (2) @(negedge clk);
    total++; if (rr_out_valid !== 1'b1 || rr_in_ready !== 4'b0000) begin bad++; $display("FAIL mid_full got=%b/%b want=1/0000", rr_out_valid, rr_in_ready); end
    rst_n = 1'b0;
    #1;
    total++; if (rr_out_valid !== 1'b0 || rr_out_evt !== 32'h0) begin bad++; $display("FAIL mid_rst_out got=%b/%h want=0/0", rr_out_valid, rr_out_evt); end
    total++; if (rr_in_ready !== 4'b0000) begin bad++; $display("FAIL mid_rst_ready got=%b want=0000", rr_in_ready); end
    in_valid = 4'b0110;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    total++; if (rr_in_ready !== 4'b0010) begin bad++; $display("FAIL mid_ready_after got=%b want=0010", rr_in_ready); end
    @(negedge clk);
    total++; if (rr_out_valid !== 1'b1 || rr_out_src !== 2'd1) begin bad++; $display("FAIL mid_first_src got=%b/%0d want=1/1", rr_out_valid, rr_out_src); end
    in_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_counter();
    apply_reset();
    out_ready = 1'b1;
    in_valid  = 4'b0001;
`ifdef SNE_EVT_MERGE_CNT_EN
    repeat (100) @(negedge clk);
    total++; if (rr_cnt !== 16'd100) begin bad++; $display("FAIL cnt_100 got=%0d want=100", rr_cnt); end
    repeat (69900) @(negedge clk);
    total++; if (rr_cnt !== 16'hFFFF) begin bad++; $display("FAIL cnt_sat got=%h want=ffff", rr_cnt); end
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    total++; if (rr_cnt !== 16'h0) begin bad++; $display("FAIL cnt_clr got=%h want=0", rr_cnt); end
    @(negedge clk);
    total++; if (rr_cnt !== 16'h1) begin bad++; $display("FAIL cnt_after_clr got=%h want=1", rr_cnt); end
`else
    repeat (5) @(negedge clk);
    total++; if (rr_cnt !== 16'h0) begin bad++; $display("FAIL cnt_tied got=%h want=0", rr_cnt); end
`endif
    in_valid = '0;
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_rr_fairness();
    test_fixed_priority();
    test_backpressure();
    test_push_pop();
    test_reset_midburst();
    test_counter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
